// File: rtl/mux_4_1_rr.sv
// Four-channel round-robin multiplexer into a single registered output word.
// Arbitration searches from the channel after the most recently granted one.
module mux_4_1_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  logic [1:0]       last_ptr;
  logic             load_en;
  logic             found;
  logic [1:0]       grant_idx;
  logic [1:0]       probe;
  logic [3:0]       grant;
  logic [WIDTH-1:0] sel_data;
  logic             transfer;

  assign load_en = !out_valid || out_ready;

  // Offsets 1..4 from last_ptr; offset 4 wraps back to last_ptr itself.
  always_comb begin
    found     = 1'b0;
    grant_idx = 2'd0;
    probe     = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      probe = last_ptr + i[1:0];
      if (!found && in_valid[probe]) begin
        found     = 1'b1;
        grant_idx = probe;
      end
    end
  end

  assign grant    = found ? (4'b0001 << grant_idx) : 4'b0000;
  assign in_ready = grant & {4{load_en && rst_n}};
  assign transfer = |in_ready;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (grant[k]) sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'b00;
      last_ptr  <= 2'b11;
    end else if (load_en) begin
      if (transfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant_idx;
        last_ptr  <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_4_1_rr.sv
// Directed bench for mux_4_1_rr: reset, round-robin rotation, backpressure,
// idle drain, priority after channel 3, and mid-stream reset.
module tb_mux_4_1_rr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int assertCount = 0;
  int failCount   = 0;

  mux_4_1_rr #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic [3:0] valid,
                               input logic [31:0] data, input logic ready);
    rst_n     = rst;
    in_valid  = valid;
    in_data   = data;
    out_ready = ready;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOuts(input string tag, input logic valid,
                           input logic [1:0] sel, input logic [7:0] data);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, {31'd0, valid});
    checkOutput({tag, "_sel"},   {30'd0, out_sel},   {30'd0, sel});
    checkOutput({tag, "_data"},  {24'd0, out_data},  {24'd0, data});
  endtask

  initial begin
    logic [3:0] expReady;
    logic [1:0] expSel;

    // Reset with every channel requesting: nothing may be accepted.
    applyStimulus(1'b0, 4'b1111, 32'hA3A2A1A0, 1'b1);
    checkOutput("rst_ready", {28'd0, in_ready}, 32'd0);
    tick();
    tick();
    checkOutput("rst_ready_hold", {28'd0, in_ready}, 32'd0);
    checkOuts("rst", 1'b0, 2'd0, 8'h00);

    // Full rotation starting at channel 0, wrapping back to channel 0.
    applyStimulus(1'b1, 4'b1111, 32'hA3A2A1A0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      expSel   = 2'(k % 4);
      expReady = 4'b0001 << expSel;
      checkOutput($sformatf("rr_ready%0d", k), {28'd0, in_ready}, {28'd0, expReady});
      tick();
      checkOuts($sformatf("rr%0d", k), 1'b1, expSel, 8'hA0 + 8'(expSel));
    end

    // Idle with consumer ready: valid drops, word and source hold.
    applyStimulus(1'b1, 4'b0000, 32'hFFFFFFFF, 1'b1);
    checkOutput("idle_ready", {28'd0, in_ready}, 32'd0);
    tick();
    checkOuts("idle", 1'b0, 2'd0, 8'hA0);

    // Channel 2 loads into an empty register, then is stalled by backpressure.
    applyStimulus(1'b1, 4'b0100, 32'h005C0000, 1'b0);
    checkOutput("bp_ready_load", {28'd0, in_ready}, 32'h4);
    tick();
    checkOuts("bp_load", 1'b1, 2'd2, 8'h5C);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("bp_ready_stall%0d", k), {28'd0, in_ready}, 32'd0);
      tick();
      checkOuts($sformatf("bp_hold%0d", k), 1'b1, 2'd2, 8'h5C);
    end
    applyStimulus(1'b1, 4'b0100, 32'h005C0000, 1'b1);
    checkOutput("bp_ready_release", {28'd0, in_ready}, 32'h4);
    tick();
    checkOuts("bp_regrant", 1'b1, 2'd2, 8'h5C);

    // Channel 3 alone twice, then channel 0 joins and wins from last_ptr=3.
    applyStimulus(1'b1, 4'b1000, 32'h33000000, 1'b1);
    checkOutput("c3_ready_a", {28'd0, in_ready}, 32'h8);
    tick();
    checkOuts("c3_a", 1'b1, 2'd3, 8'h33);
    checkOutput("c3_ready_b", {28'd0, in_ready}, 32'h8);
    tick();
    checkOuts("c3_b", 1'b1, 2'd3, 8'h33);
    applyStimulus(1'b1, 4'b1001, 32'h33000011, 1'b1);
    checkOutput("c30_ready_0", {28'd0, in_ready}, 32'h1);
    tick();
    checkOuts("c30_ch0", 1'b1, 2'd0, 8'h11);
    checkOutput("c30_ready_3", {28'd0, in_ready}, 32'h8);
    tick();
    checkOuts("c30_ch3", 1'b1, 2'd3, 8'h33);

    // Mid-stream reset discards the held word and restores channel 0 priority.
    applyStimulus(1'b0, 4'b0010, 32'h00002200, 1'b1);
    checkOutput("mrst_ready", {28'd0, in_ready}, 32'd0);
    tick();
    checkOuts("mrst", 1'b0, 2'd0, 8'h00);
    applyStimulus(1'b1, 4'b0010, 32'h00002200, 1'b1);
    checkOutput("mrst_ready_rel", {28'd0, in_ready}, 32'h2);
    tick();
    checkOuts("mrst_ch1", 1'b1, 2'd1, 8'h22);

    // A stalled requester that withdraws leaves the pointer untouched.
    applyStimulus(1'b1, 4'b0100, 32'h00440000, 1'b0);
    checkOutput("wd_ready_stall", {28'd0, in_ready}, 32'd0);
    tick();
    checkOuts("wd_hold", 1'b1, 2'd1, 8'h22);
    applyStimulus(1'b1, 4'b1001, 32'h88000099, 1'b1);
    checkOutput("wd_ready_after", {28'd0, in_ready}, 32'h8);
    tick();
    checkOuts("wd_ch3", 1'b1, 2'd3, 8'h88);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
